// File: rtl/sos_module.sv
// sos_module: plays one Morse "SOS" on a passive buzzer pin after a start pulse.
// Marks are a gated square-wave tone; spaces are silent. All timing is derived
// from a 1 ms prescaler so the whole sequence scales with T1MS.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for SOS_En_Sig, Pin_Out=0, Busy=0
// MARK  | element e sounding (dot or dash), tone on Pin_Out, Busy=1
// SPACE | silence after element e (intra-letter or letter gap), Busy=1

module sos_module #(
    parameter int T1MS          = 50_000,
    parameter int DOT_MS        = 100,
    parameter int DASH_MS       = 300,
    parameter int GAP_MS        = 100,
    parameter int LETTER_GAP_MS = 300,
    parameter int TONE_HALF     = 25_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic SOS_En_Sig,
    output logic Pin_Out,
    output logic Busy,
    output logic Done
);

    localparam int MAX_MARK_MS  = (DOT_MS > DASH_MS) ? DOT_MS : DASH_MS;
    localparam int MAX_SPACE_MS = (GAP_MS > LETTER_GAP_MS) ? GAP_MS : LETTER_GAP_MS;
    localparam int MAX_MS       = (MAX_MARK_MS > MAX_SPACE_MS) ? MAX_MARK_MS : MAX_SPACE_MS;

    localparam int PW = $clog2(T1MS + 1);
    localparam int MW = $clog2(MAX_MS + 1);
    localparam int TW = $clog2(TONE_HALF + 1);

    // Terminal values: counters run 0..N-1 and compare against N-1.
    localparam logic [PW-1:0] PRE_LAST  = PW'(T1MS - 1);
    localparam logic [MW-1:0] DOT_LAST  = MW'(DOT_MS - 1);
    localparam logic [MW-1:0] DASH_LAST = MW'(DASH_MS - 1);
    localparam logic [MW-1:0] GAP_LAST  = MW'(GAP_MS - 1);
    localparam logic [MW-1:0] LGAP_LAST = MW'(LETTER_GAP_MS - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
    localparam logic [3:0]    E_LAST    = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    elem_q;
    logic [PW-1:0] pre_q;
    logic [MW-1:0] ms_q;
    logic [TW-1:0] tone_q;
    logic          pin_q;
    logic          busy_q;
    logic          done_q;

    logic          pre_wrap;
    logic          tone_wrap;
    logic          is_dash;
    logic          is_letter_end;
    logic [MW-1:0] seg_last_ms;
    logic          seg_end;

    // Decode the end of the current MARK/SPACE segment from the counters.
    always_comb begin
        pre_wrap      = (pre_q == PRE_LAST);
        tone_wrap     = (tone_q == TONE_LAST);
        is_dash       = (elem_q >= 4'd3) && (elem_q <= 4'd5);
        is_letter_end = (elem_q == 4'd2) || (elem_q == 4'd5);
        if (state_q == MARK) begin
            seg_last_ms = is_dash ? DASH_LAST : DOT_LAST;
        end else begin
            seg_last_ms = is_letter_end ? LGAP_LAST : GAP_LAST;
        end
        seg_end = pre_wrap && (ms_q == seg_last_ms);
    end

    // Sequencer FSM with prescaler, ms counter, tone generator and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            elem_q  <= 4'd0;
            pre_q   <= '0;
            ms_q    <= '0;
            tone_q  <= '0;
            pin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pin_q <= 1'b0;
                    if (SOS_En_Sig) begin
                        state_q <= MARK;
                        elem_q  <= 4'd0;
                        pre_q   <= '0;
                        ms_q    <= '0;
                        tone_q  <= '0;
                        pin_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                MARK: begin
                    if (seg_end) begin
                        // Tone is cut on exit regardless of its phase.
                        pre_q  <= '0;
                        ms_q   <= '0;
                        tone_q <= '0;
                        pin_q  <= 1'b0;
                        if (elem_q == E_LAST) begin
                            state_q <= IDLE;
                            elem_q  <= 4'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SPACE;
                        end
                    end else begin
                        if (pre_wrap) begin
                            pre_q <= '0;
                            ms_q  <= ms_q + MW'(1);
                        end else begin
                            pre_q <= pre_q + PW'(1);
                        end
                        if (tone_wrap) begin
                            tone_q <= '0;
                            pin_q  <= ~pin_q;
                        end else begin
                            tone_q <= tone_q + TW'(1);
                        end
                    end
                end

                SPACE: begin
                    pin_q <= 1'b0;
                    if (seg_end) begin
                        state_q <= MARK;
                        elem_q  <= elem_q + 4'd1;
                        pre_q   <= '0;
                        ms_q    <= '0;
                        tone_q  <= '0;
                        pin_q   <= 1'b1;
                    end else if (pre_wrap) begin
                        pre_q <= '0;
                        ms_q  <= ms_q + MW'(1);
                    end else begin
                        pre_q <= pre_q + PW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    elem_q  <= 4'd0;
                    pre_q   <= '0;
                    ms_q    <= '0;
                    tone_q  <= '0;
                    pin_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Pin_Out = pin_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule
